car_pass_detector: RTL and testbench

//   Input-side counterpart of the parking controller: converts two raw light-beam

---
 rtl/car_pass_detector.sv | 243 ++++++++++++++++++++++++
 tb/tb_car_pass_detector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/car_pass_detector.sv
// Gate beam front end: sync, debounce and direction decode of two beams.
// Emits qualified one-cycle entry/exit/reject events with the chosen slot.

module car_pass_debounce #(
  parameter int CYCLES = 400000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int DW = $clog2(CYCLES + 1);
  localparam logic [DW-1:0] LAST = DW'(CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] cnt;

  // two-flop synchroniser for the asynchronous beam
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // accept a new level only after it has been stable long enough
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync2 == filt) begin
      cnt  <= '0;
    end else if (cnt == LAST) begin
      filt <= sync2;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + DW'(1);
    end
  end

endmodule

module car_pass_detector #(
  parameter int DEBOUNCE_CYCLES = 400000,
  parameter int TIMEOUT_CYCLES  = 2**26 - 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beam_a,
  input  logic       beam_b,
  input  logic [1:0] slot_sel,
  input  logic [3:0] occupancy,
  output logic       entry_pulse,
  output logic       exit_pulse,
  output logic       reject_pulse,
  output logic [1:0] event_slot,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    E1,
    E2,
    E3,
    X1,
    X2,
    X3
  } state_t;

  logic          fa;
  logic          fb;
  logic [1:0]    fab;
  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] tcnt;
  logic          armed;
  logic          armed_nx;
  logic          done_entry;
  logic          done_exit;
  logic          occ_bit;
  logic          entry_d;
  logic          exit_d;
  logic          reject_d;
  logic [1:0]    slot_d;

  car_pass_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_db_a (
    .clk  (clk),
    .reset(reset),
    .raw  (beam_a),
    .filt (fa)
  );

  car_pass_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_db_b (
    .clk  (clk),
    .reset(reset),
    .raw  (beam_b),
    .filt (fb)
  );

  assign fab     = {fa, fb};
  assign occ_bit = occupancy[slot_sel];

  // passage state, re-arm flag and stuck-passage timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      armed <= 1'b1;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      armed <= armed_nx;
      if (state_nx != state)
        tcnt <= '0;
      else if (state != IDLE)
        tcnt <= tcnt + TW'(1);
    end
  end

  // sequence decode; a timeout forces IDLE and waits for clear beams
  always_comb begin
    state_nx   = state;
    armed_nx   = armed;
    done_entry = 1'b0;
    done_exit  = 1'b0;
    if (state != IDLE && tcnt == TO_LAST) begin
      state_nx = IDLE;
      armed_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!armed) begin
            if (fab == 2'b00)
              armed_nx = 1'b1;
          end else if (fab == 2'b10) begin
            state_nx = E1;
          end else if (fab == 2'b01) begin
            state_nx = X1;
          end
        end
        E1: begin
          if (fab == 2'b11)
            state_nx = E2;
          else if (fab == 2'b00)
            state_nx = IDLE;
        end
        E2: begin
          if (fab == 2'b01)
            state_nx = E3;
          else if (fab == 2'b10)
            state_nx = E1;
          else if (fab == 2'b00)
            state_nx = IDLE;
        end
        E3: begin
          if (fab == 2'b00) begin
            state_nx   = IDLE;
            done_entry = 1'b1;
          end else if (fab == 2'b11) begin
            state_nx = E2;
          end else if (fab == 2'b10) begin
            state_nx = IDLE;
          end
        end
        X1: begin
          if (fab == 2'b11)
            state_nx = X2;
          else if (fab == 2'b00)
            state_nx = IDLE;
        end
        X2: begin
          if (fab == 2'b10)
            state_nx = X3;
          else if (fab == 2'b01)
            state_nx = X1;
          else if (fab == 2'b00)
            state_nx = IDLE;
        end
        X3: begin
          if (fab == 2'b00) begin
            state_nx  = IDLE;
            done_exit = 1'b1;
          end else if (fab == 2'b11) begin
            state_nx = X2;
          end else if (fab == 2'b01) begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // qualify a completed passage against slot occupancy
  always_comb begin
    entry_d  = 1'b0;
    exit_d   = 1'b0;
    reject_d = 1'b0;
    slot_d   = event_slot;
    unique case (1'b1)
      done_entry: begin
        entry_d  = ~occ_bit;
        reject_d = occ_bit;
        slot_d   = slot_sel;
      end
      done_exit: begin
        exit_d   = occ_bit;
        reject_d = ~occ_bit;
        slot_d   = slot_sel;
      end
      default: ;
    endcase
  end

  // registered event outputs and busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_pulse  <= 1'b0;
      exit_pulse   <= 1'b0;
      reject_pulse <= 1'b0;
      event_slot   <= 2'd0;
      busy         <= 1'b0;
    end else begin
      entry_pulse  <= entry_d;
      exit_pulse   <= exit_d;
      reject_pulse <= reject_d;
      event_slot   <= slot_d;
      busy         <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_car_pass_detector.sv
// Directed bench for car_pass_detector with short debounce/timeout.
// Pulse/busy activity is tallied at negedge and checked per scenario.

module tb_car_pass_detector;

  logic       clk;
  logic       reset;
  logic       beam_a;
  logic       beam_b;
  logic [1:0] slot_sel;
  logic [3:0] occupancy;
  logic       entry_pulse;
  logic       exit_pulse;
  logic       reject_pulse;
  logic [1:0] event_slot;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;
  int n_entry  = 0;
  int n_exit   = 0;
  int n_reject = 0;
  int n_busy   = 0;
  int n_multi  = 0;
  int n_long   = 0;
  logic p_entry  = 1'b0;
  logic p_exit   = 1'b0;
  logic p_reject = 1'b0;

  car_pass_detector #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .beam_a      (beam_a),
    .beam_b      (beam_b),
    .slot_sel    (slot_sel),
    .occupancy   (occupancy),
    .entry_pulse (entry_pulse),
    .exit_pulse  (exit_pulse),
    .reject_pulse(reject_pulse),
    .event_slot  (event_slot),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tally outputs away from the active edge
  always @(negedge clk) begin
    if (entry_pulse)  n_entry++;
    if (exit_pulse)   n_exit++;
    if (reject_pulse) n_reject++;
    if (busy)         n_busy++;
    if (int'(entry_pulse) + int'(exit_pulse) + int'(reject_pulse) > 1)
      n_multi++;
    if ((entry_pulse && p_entry) || (exit_pulse && p_exit) ||
        (reject_pulse && p_reject))
      n_long++;
    p_entry  = entry_pulse;
    p_exit   = exit_pulse;
    p_reject = reject_pulse;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_entry  = 0;
    n_exit   = 0;
    n_reject = 0;
    n_busy   = 0;
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    beam_a = a;
    beam_b = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int outs();
    return int'({entry_pulse, exit_pulse, reject_pulse, event_slot, busy});
  endfunction

  initial begin
    reset     = 1'b0;
    beam_a    = 1'b0;
    beam_b    = 1'b0;
    slot_sel  = 2'd0;
    occupancy = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 0);
    reset = 1'b1;
    hold(0, 0, 5);

    // 1: entry into free slot 2
    occupancy = 4'b0000;
    slot_sel  = 2'd2;
    clr();
    hold(1, 0, 10);
    chk("t1_busy_mid", int'(busy), 1);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 10);
    chk("t1_entry", n_entry, 1);
    chk("t1_exit", n_exit, 0);
    chk("t1_reject", n_reject, 0);
    chk("t1_slot", int'(event_slot), 2);
    chk("t1_busy_end", int'(busy), 0);

    // 2: exit from occupied slot 1
    occupancy = 4'b0010;
    slot_sel  = 2'd1;
    clr();
    hold(0, 1, 10);
    hold(1, 1, 10);
    hold(1, 0, 10);
    hold(0, 0, 10);
    chk("t2_exit", n_exit, 1);
    chk("t2_entry", n_entry, 0);
    chk("t2_reject", n_reject, 0);
    chk("t2_slot", int'(event_slot), 1);

    // 3: entry into occupied slot 0 is rejected
    occupancy = 4'b1111;
    slot_sel  = 2'd0;
    clr();
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 10);
    chk("t3_reject", n_reject, 1);
    chk("t3_entry", n_entry, 0);
    chk("t3_exit", n_exit, 0);
    chk("t3_slot", int'(event_slot), 0);

    // 4: 3-cycle glitch is filtered, then an aborted A-only passage
    occupancy = 4'b0000;
    slot_sel  = 2'd3;
    clr();
    hold(1, 0, 3);
    hold(0, 0, 12);
    chk("t4_glitch_busy", n_busy, 0);
    hold(1, 0, 10);
    chk("t4_a_busy", int'(busy), 1);
    hold(0, 0, 10);
    chk("t4_busy_end", int'(busy), 0);
    chk("t4_pulses", n_entry + n_exit + n_reject, 0);
    chk("t4_slot_kept", int'(event_slot), 0);

    // 5: stuck beam times out, re-arm only after beams clear
    slot_sel = 2'd3;
    clr();
    hold(1, 0, 30);
    chk("t5_busy_early", int'(busy), 1);
    hold(1, 0, 70);
    chk("t5_busy_timeout", int'(busy), 0);
    clr();
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 10);
    chk("t5_disarmed_busy", n_busy, 0);
    chk("t5_disarmed_pulses", n_entry + n_exit + n_reject, 0);
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 10);
    chk("t5_rearmed_entry", n_entry, 1);
    chk("t5_slot", int'(event_slot), 3);

    // 6: reset while in E3 discards the passage
    occupancy = 4'b0000;
    slot_sel  = 2'd1;
    clr();
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(0, 1, 10);
    chk("t6_busy_e3", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("t6_reset_outputs", outs(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_reset_held", outs(), 0);
    beam_b = 1'b0;
    reset  = 1'b1;
    n_busy = 0;
    hold(0, 0, 20);
    chk("t6_pulses", n_entry + n_exit + n_reject, 0);
    chk("t6_busy_after", n_busy, 0);
    chk("t6_slot", int'(event_slot), 0);

    chk("one_hot_pulses", n_multi, 0);
    chk("single_cycle_pulses", n_long, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
